// File: rtl/tone_pkg.sv
// ---- tone_pkg : note-to-period decode shared by the tone generator (rev 1.0) ----
`default_nettype none
package tone_pkg;

  localparam int PERIOD_W = 23;
  localparam int LEVEL_W  = 4;

  localparam logic [7:0] NOTE_MIN = 8'd12;
  localparam logic [7:0] NOTE_MAX = 8'd119;

  // Octave-0 periods in clk cycles; higher octaves are logical right shifts.
  localparam logic [PERIOD_W-1:0] BASE [12] = '{
    23'd6115610, 23'd5772367, 23'd5448389, 23'd5142594,
    23'd4853963, 23'd4580858, 23'd4325483, 23'd4081632,
    23'd3854398, 23'd3636363, 23'd3432458, 23'd3239437
  };

  typedef enum logic [0:0] {
    VOICE_IDLE = 1'b0,
    VOICE_RUN  = 1'b1
  } voice_state_e;

  function automatic logic [PERIOD_W-1:0] note_to_period(input logic [7:0] note);
    logic [7:0] n;
    logic [3:0] oct;
    logic [3:0] semi;
    if (note < NOTE_MIN || note > NOTE_MAX) begin
      return '0;
    end
    n    = note - NOTE_MIN;
    oct  = 4'(n / 8'd12);
    semi = 4'(n % 8'd12);
    return BASE[semi] >> oct;
  endfunction

endpackage
`default_nettype wire

// File: rtl/poly_tone_pwm_if.sv
// ---- poly_tone_pwm_if : note/level inputs and audio outputs of the tone generator (rev 1.0) ----
`default_nettype none
interface poly_tone_pwm_if #(
  parameter int NUM_VOICES = 4
);
  logic [NUM_VOICES*8-1:0] note;
  logic [NUM_VOICES*4-1:0] level;
  logic [NUM_VOICES-1:0]   voice_active;
  logic                    pwm_out;

  modport master (output note, output level, input voice_active, input pwm_out);
  modport slave  (input note, input level, output voice_active, output pwm_out);
endinterface
`default_nettype wire

// File: rtl/tone_voice.sv
// ---- tone_voice : one square-wave voice, period changes only at the wrap (rev 1.0) ----
`default_nettype none
module tone_voice
  import tone_pkg::*;
#(
  parameter int CNT_W = PERIOD_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] note,
  output logic       wave,
  output logic       active
);

  voice_state_e     state_q, state_d;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wave_q, wave_d;
  logic             active_q, active_d;

  always_comb begin
    pending_d = CNT_W'(note_to_period(note));
    state_d   = state_q;
    period_d  = period_q;
    cnt_d     = cnt_q;
    if (state_q == VOICE_IDLE) begin
      cnt_d    = '0;
      period_d = '0;
      if (pending_q != '0) begin
        state_d  = VOICE_RUN;
        period_d = pending_q;
      end
    end else if (cnt_q == period_q - CNT_W'(1)) begin
      // Only the wrap cycle looks at pending, keeping pitch changes phase-continuous.
      cnt_d = '0;
      if (pending_q == '0) begin
        state_d  = VOICE_IDLE;
        period_d = '0;
      end else begin
        period_d = pending_q;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    active_d = (state_d == VOICE_RUN);
    wave_d   = active_d && (cnt_d < (period_d >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= VOICE_IDLE;
      pending_q <= '0;
      period_q  <= '0;
      cnt_q     <= '0;
      wave_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      wave_q    <= wave_d;
      active_q  <= active_d;
    end
  end

  assign wave   = wave_q;
  assign active = active_q;

endmodule
`default_nettype wire

// File: rtl/poly_tone_pwm.sv
// ---- poly_tone_pwm : polyphonic tone mixer with 1-bit sigma-delta output (rev 1.0) ----
`default_nettype none
module poly_tone_pwm
  import tone_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int CNT_W      = 23
) (
  input  logic             clk,
  input  logic             rst_n,
  poly_tone_pwm_if.slave   bus
);

  localparam int FULL  = ((1 << LEVEL_W) - 1) * NUM_VOICES;
  localparam int MIX_W = $clog2(2 * FULL);
  localparam logic [MIX_W-1:0] FULL_C = MIX_W'(FULL);

  logic [NUM_VOICES-1:0] wave_w;
  logic [NUM_VOICES-1:0] active_w;

  generate
    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
      tone_voice #(
        .CNT_W (CNT_W)
      ) u_voice (
        .clk    (clk),
        .rst_n  (rst_n),
        .note   (bus.note[8*v +: 8]),
        .wave   (wave_w[v]),
        .active (active_w[v])
      );
    end
  endgenerate

  logic [MIX_W-1:0] mix_q, mix_d;
  logic [MIX_W-1:0] acc_q, acc_d;
  logic             pwm_q, pwm_d;
  logic [MIX_W-1:0] sum_w;

  // acc stays below FULL, so acc + mix < 2*FULL always fits MIX_W bits.
  always_comb begin
    mix_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (wave_w[v]) begin
        mix_d = mix_d + MIX_W'(bus.level[LEVEL_W*v +: LEVEL_W]);
      end
    end
    sum_w = acc_q + mix_q;
    if (sum_w >= FULL_C) begin
      pwm_d = 1'b1;
      acc_d = sum_w - FULL_C;
    end else begin
      pwm_d = 1'b0;
      acc_d = sum_w;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mix_q <= '0;
      acc_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      mix_q <= mix_d;
      acc_q <= acc_d;
      pwm_q <= pwm_d;
    end
  end

  assign bus.voice_active = active_w;
  assign bus.pwm_out      = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_tone_pwm.sv
// ---- tb_poly_tone_pwm : directed vectors for the polyphonic tone generator (rev 1.0) ----
`default_nettype none
module tb_poly_tone_pwm;
  import tone_pkg::*;

  localparam int NV = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_tone_pwm_if #(.NUM_VOICES(NV)) bus_if ();

  poly_tone_pwm #(
    .NUM_VOICES (NV),
    .CNT_W      (23)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;
  int c = 0;

  typedef struct {
    logic [7:0]  note;
    logic [22:0] period;
  } per_vec_t;

  typedef struct {
    logic [31:0] notes;
    logic [15:0] levels;
    logic [3:0]  act;
    int          ones;
  } mix_vec_t;

  per_vec_t ptab [14];
  mix_vec_t mtab [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    c++;
  endtask

  task automatic restart(input logic [31:0] notes, input logic [15:0] levels);
    @(negedge clk);
    rst_n = 1'b0;
    bus_if.note  = notes;
    bus_if.level = levels;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    c = 0;
  endtask

  // Full-scale run: 119 (12654) twice, then 118 (13408) from the second wrap.
  function automatic logic fs_exp(input int cyc);
    return (cyc >= 4 && cyc <= 6330) || (cyc >= 12658 && cyc <= 18984) ||
           (cyc >= 25312 && cyc <= 32015);
  endfunction

  initial begin
    int bad_p;
    int bad_a;
    int ones;
    logic exp_p;
    logic [3:0] exp_a;

    bus_if.note  = '0;
    bus_if.level = '0;

    ptab[0]  = '{8'd0,   23'd0};
    ptab[1]  = '{8'd11,  23'd0};
    ptab[2]  = '{8'd12,  23'd6115610};
    ptab[3]  = '{8'd13,  23'd5772367};
    ptab[4]  = '{8'd23,  23'd3239437};
    ptab[5]  = '{8'd24,  23'd3057805};
    ptab[6]  = '{8'd60,  23'd382225};
    ptab[7]  = '{8'd69,  23'd227272};
    ptab[8]  = '{8'd81,  23'd113636};
    ptab[9]  = '{8'd107, 23'd25308};
    ptab[10] = '{8'd118, 23'd13408};
    ptab[11] = '{8'd119, 23'd12654};
    ptab[12] = '{8'd120, 23'd0};
    ptab[13] = '{8'd255, 23'd0};

    mtab[0] = '{{4{8'd119}},                   16'h000F, 4'b1111, 15};
    mtab[1] = '{{4{8'd119}},                   16'h7053, 4'b1111, 15};
    mtab[2] = '{{4{8'd119}},                   16'hFFFF, 4'b1111, 60};
    mtab[3] = '{{4{8'd119}},                   16'h0000, 4'b1111, 0};
    mtab[4] = '{{8'd11, 8'd119, 8'd0, 8'd119}, 16'hFFFF, 4'b0101, 30};
    mtab[5] = '{{8'd255, 8'd12, 8'd119, 8'd120}, 16'h8421, 4'b0110, 6};
    mtab[6] = '{{8'd0, 8'd0, 8'd0, 8'd60},     16'h0009, 4'b0001, 9};

    for (int i = 0; i < 14; i++) begin
      check($sformatf("period_note%0d", ptab[i].note),
            32'(note_to_period(ptab[i].note)), 32'(ptab[i].period));
    end

    // Reset held with a note applied, then release and mid-note reset.
    repeat (2) @(negedge clk);
    bus_if.note  = 32'd69;
    bus_if.level = 16'h000F;
    repeat (3) @(negedge clk);
    check("rst_pwm", 32'(bus_if.pwm_out), 32'd0);
    check("rst_active", 32'(bus_if.voice_active), 32'd0);
    rst_n = 1'b1;
    c = 0;
    step();
    check("rel_active_t1", 32'(bus_if.voice_active), 32'd0);
    step();
    check("rel_active_t2", 32'(bus_if.voice_active), 32'd1);
    repeat (3) step();
    rst_n = 1'b0;
    #1;
    check("midreset_active", 32'(bus_if.voice_active), 32'd0);
    check("midreset_pwm", 32'(bus_if.pwm_out), 32'd0);

    // Single voice 119 at level 15, turned off during the low half.
    restart(32'd119, 16'h000F);
    bad_p = 0;
    bad_a = 0;
    ones  = 0;
    while (c < 12660) begin
      step();
      exp_p = (c >= 7 && c <= 6330 && ((c - 3) % 4 == 0));
      exp_a = (c >= 2 && c <= 12655) ? 4'b0001 : 4'b0000;
      if (bus_if.pwm_out !== exp_p) bad_p++;
      if (bus_if.voice_active !== exp_a) bad_a++;
      if (c <= 6330 && bus_if.pwm_out === 1'b1) ones++;
      if (c == 12655) check("off_active_wrap", 32'(bus_if.voice_active), 32'd1);
      if (c == 12656) check("off_active_after", 32'(bus_if.voice_active), 32'd0);
      if (c == 12000) bus_if.note = '0;
    end
    check("single_pwm_errs", 32'(bad_p), 32'd0);
    check("single_high_ones", 32'(ones), 32'd1581);
    check("single_active_errs", 32'(bad_a), 32'd0);

    // Full scale on all voices; mid-period switch 119 -> 118 waits for the wrap.
    restart({4{8'd119}}, 16'hFFFF);
    bad_p = 0;
    bad_a = 0;
    while (c < 32020) begin
      step();
      if (bus_if.pwm_out !== fs_exp(c)) bad_p++;
      exp_a = (c >= 2) ? 4'b1111 : 4'b0000;
      if (bus_if.voice_active !== exp_a) bad_a++;
      if (c == 15000) bus_if.note = {4{8'd118}};
      if (c == 25311) check("glitch_old_low_end", 32'(bus_if.pwm_out), 32'd0);
      if (c == 25312) check("glitch_new_start", 32'(bus_if.pwm_out), 32'd1);
      if (c == 32015) check("glitch_new_high_end", 32'(bus_if.pwm_out), 32'd1);
      if (c == 32016) check("glitch_new_low_start", 32'(bus_if.pwm_out), 32'd0);
    end
    check("fullscale_pwm_errs", 32'(bad_p), 32'd0);
    check("fullscale_active_errs", 32'(bad_a), 32'd0);

    // Mixer/modulator vectors: one 60-cycle window after the pipeline fills.
    for (int i = 0; i < 7; i++) begin
      restart(mtab[i].notes, mtab[i].levels);
      ones = 0;
      while (c < 63) begin
        step();
        if (c >= 4 && bus_if.pwm_out === 1'b1) ones++;
      end
      check($sformatf("mix%0d_active", i), 32'(bus_if.voice_active), 32'(mtab[i].act));
      check($sformatf("mix%0d_ones", i), 32'(ones), 32'(mtab[i].ones));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
